// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the mdu_hilo multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int MAX_W = 64;
    // LO value written on divide by zero (all ones, sliced to WIDTH by the user)
    localparam logic [MAX_W-1:0] DIV0_LO = {MAX_W{1'b1}};

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational conditional two's-complement negate.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional multiply early-out when MDU_EARLY_OUT_EN is defined.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_r, state_nxt_s;
    logic                 is_div_r, div0_r, neg_q_r, neg_rem_r;
    logic [WIDTH-1:0]     opa_r, opb_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     hi_r, lo_r;

    logic                 neg_a_s, neg_b_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0]   mul_acc_s, mul_res_s, div_acc_s;
    logic [WIDTH-1:0]     mplier_nxt_s, rem_src_s;
    logic                 calc_last_s, mul_done_s, mul_zero_s, calc_skip_s, calc_end_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s, rem_fix_s;
    logic [WIDTH-1:0]     hi_nxt_s, lo_nxt_s;
    logic                 busy_nxt_s, done_nxt_s;

    assign neg_a_s = op_is_signed(op) & a[WIDTH-1];
    assign neg_b_s = op_is_signed(op) & b[WIDTH-1];

    mdu_signfix #(.W(WIDTH))   u_mag_a (.in(a), .neg(neg_a_s), .out(mag_a_s));
    mdu_signfix #(.W(WIDTH))   u_mag_b (.in(b), .neg(neg_b_s), .out(mag_b_s));
    mdu_signfix #(.W(2*WIDTH)) u_prod  (.in(acc_r), .neg(neg_q_r), .out(prod_fix_s));
    mdu_signfix #(.W(WIDTH))   u_quo   (.in(acc_r[WIDTH-1:0]), .neg(neg_q_r), .out(quo_fix_s));
    mdu_signfix #(.W(WIDTH))   u_rem   (.in(rem_src_s), .neg(neg_rem_r), .out(rem_fix_s));

    // On divide by zero the untouched dividend magnitude sits in the low half
    assign rem_src_s = div0_r ? acc_r[WIDTH-1:0] : acc_r[2*WIDTH-1:WIDTH];

    // One shift-add or restoring-subtract step of the datapath
    always_comb begin
        mul_sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (opb_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
        mul_acc_s    = {mul_sum_s, acc_r[WIDTH-1:1]};
        mplier_nxt_s = opb_r >> 1;
        div_shift_s  = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s   = div_shift_s - {1'b0, opb_r};
        if (div_diff_s[WIDTH]) begin
            div_acc_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
        calc_last_s = (cnt_r == LAST_CNT);
`ifdef MDU_EARLY_OUT_EN
        // Remaining iterations would only shift right; apply them in one step
        mul_zero_s = ~is_div_r & (opb_r == {WIDTH{1'b0}});
        mul_done_s = calc_last_s | (mplier_nxt_s == {WIDTH{1'b0}});
        mul_res_s  = mul_done_s ? (mul_acc_s >> (LAST_CNT - cnt_r)) : mul_acc_s;
`else
        mul_zero_s = 1'b0;
        mul_done_s = calc_last_s;
        mul_res_s  = mul_acc_s;
`endif
        calc_skip_s = div0_r | mul_zero_s;
        calc_end_s  = is_div_r ? calc_last_s : mul_done_s;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_CALC;
                else       state_nxt_s = S_IDLE;
            end
            S_CALC: begin
                if (calc_skip_s || calc_end_s) state_nxt_s = S_FIX;
                else                           state_nxt_s = S_CALC;
            end
            S_FIX:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        hi_nxt_s   = hi_r;
        lo_nxt_s   = lo_r;
        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_r == S_FIX);
        case (state_r)
            S_IDLE: begin
                if (!start) begin
                    if (we_hi) hi_nxt_s = wdata;
                    else       hi_nxt_s = hi_r;
                    if (we_lo) lo_nxt_s = wdata;
                    else       lo_nxt_s = lo_r;
                end else begin
                    hi_nxt_s = hi_r;
                    lo_nxt_s = lo_r;
                end
            end
            S_FIX: begin
                if (is_div_r) begin
                    hi_nxt_s = rem_fix_s;
                    lo_nxt_s = div0_r ? DIV0_LO[WIDTH-1:0] : quo_fix_s;
                end else begin
                    hi_nxt_s = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_nxt_s = prod_fix_s[WIDTH-1:0];
                end
            end
            default: begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_r  <= 1'b0;
            div0_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            opa_r     <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        is_div_r  <= op_is_div(op);
                        div0_r    <= op_is_div(op) & (b == {WIDTH{1'b0}});
                        neg_q_r   <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= neg_a_s;
                        opa_r     <= mag_a_s;
                        opb_r     <= mag_b_s;
                        acc_r     <= op_is_div(op) ? {{WIDTH{1'b0}}, mag_a_s}
                                                   : {(2*WIDTH){1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                S_CALC: begin
                    if (!calc_skip_s) begin
                        acc_r <= is_div_r ? div_acc_s : mul_res_s;
                        opb_r <= is_div_r ? opb_r : mplier_nxt_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
